// File: rtl/row_rotate_mcu_if.sv
`default_nettype none
// ============================================================================
// Module   : row_rotate_mcu_if
// Brief    : Host / bank / convolver bus bundle for row_rotate_mcu.
// Revision : 1.0 - initial release
// ============================================================================
interface row_rotate_mcu_if #(
    parameter int N           = 2,
    parameter int K           = 3,
    parameter int BITS_IMAGEN = 11,
    parameter int BITS_ADDR   = 10
);
    localparam int M         = N + K - 1;
    localparam int BITS_DATA = BITS_IMAGEN;
    localparam int BASE_W    = $clog2(M);

    logic                          i_sop;
    logic                          i_eop;
    logic                          i_chblk;
    logic                          i_valid;
    logic                          i_rd;
    logic [BITS_DATA-1:0]          i_Data;
    logic [N*BITS_IMAGEN-1:0]      i_DataConv;
    logic [M*BITS_IMAGEN-1:0]      i_MemData;
    logic [BITS_ADDR-1:0]          i_WAddr;
    logic [BITS_ADDR-1:0]          i_RAddr;
    logic [K*N*BITS_IMAGEN-1:0]    o_DataConv;
    logic [M*BITS_IMAGEN-1:0]      o_MemData;
    logic [M-1:0]                  o_we;
    logic [BITS_DATA-1:0]          o_Data;
    logic [BITS_ADDR-1:0]          o_WAddr;
    logic [BITS_ADDR-1:0]          o_RAddr;
    logic [1:0]                    o_state;
    logic [BASE_W-1:0]             o_base;

    modport slave (
        input  i_sop, i_eop, i_chblk, i_valid, i_rd, i_Data, i_DataConv,
               i_MemData, i_WAddr, i_RAddr,
        output o_DataConv, o_MemData, o_we, o_Data, o_WAddr, o_RAddr,
               o_state, o_base
    );

    modport master (
        output i_sop, i_eop, i_chblk, i_valid, i_rd, i_Data, i_DataConv,
               i_MemData, i_WAddr, i_RAddr,
        input  o_DataConv, o_MemData, o_we, o_Data, o_WAddr, o_RAddr,
               o_state, o_base
    );
endinterface
`default_nettype wire

// File: rtl/row_rotate_mcu.sv
`default_nettype none
// ============================================================================
// Module   : row_rotate_mcu
// Brief    : Rotating row-bank controller feeding N convolver lanes with K taps.
//            Optional macro MCU_OREG_EN registers data/enable/address outputs.
// Revision : 1.0 - initial release
// ============================================================================
module row_rotate_mcu #(
    parameter int N           = 2,
    parameter int K           = 3,
    parameter int BITS_IMAGEN = 11,
    parameter int BITS_ADDR   = 10
) (
    input  logic             clk,
    input  logic             rst,
    row_rotate_mcu_if.slave  bus
);
    localparam int M         = N + K - 1;
    localparam int BITS_DATA = BITS_IMAGEN;
    localparam int BASE_W    = $clog2(M);
    localparam int FILL_W    = $clog2(N + 1);
    localparam int RSEL_W    = (N > 1) ? $clog2(N) : 1;

    localparam logic [BASE_W-1:0] c_LAST_BANK = BASE_W'(M - 1);
    localparam logic [RSEL_W-1:0] c_LAST_LANE = RSEL_W'(N - 1);
    localparam logic [FILL_W-1:0] c_LAST_FILL = FILL_W'(N - 1);
    localparam logic [BASE_W:0]   c_M         = (BASE_W + 1)'(M);
    localparam logic [BASE_W:0]   c_N         = (BASE_W + 1)'(N);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_RUN    = 2'd2,
        S_REFILL = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [BASE_W-1:0]   r_base,  w_base_nxt;
    logic [BASE_W-1:0]   r_wptr,  w_wptr_nxt;
    logic [FILL_W-1:0]   r_fill,  w_fill_nxt;
    logic [RSEL_W-1:0]   r_rsel,  w_rsel_nxt;
    logic                w_wr_en;
    logic [BASE_W:0]     w_base_sum;
    logic [BASE_W-1:0]   w_wptr_inc;

    logic [K*N*BITS_IMAGEN-1:0] w_taps;
    logic [M*BITS_IMAGEN-1:0]   w_memdata;
    logic [M-1:0]               w_we;
    logic [BITS_DATA-1:0]       w_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_wptr  <= '0;
            r_fill  <= '0;
            r_rsel  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_base  <= w_base_nxt;
            r_wptr  <= w_wptr_nxt;
            r_fill  <= w_fill_nxt;
            r_rsel  <= w_rsel_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_wptr_nxt  = r_wptr;
        w_fill_nxt  = r_fill;
        w_wr_en     = 1'b0;
        w_rsel_nxt  = r_rsel;
        if (bus.i_rd)
            w_rsel_nxt = (r_rsel == c_LAST_LANE) ? '0 : r_rsel + RSEL_W'(1);
        w_base_sum  = {1'b0, r_base} + c_N;
        w_wptr_inc  = (r_wptr == c_LAST_BANK) ? '0 : r_wptr + BASE_W'(1);

        // i_eop outranks i_chblk in every state that honours both
        case (r_state)
            S_IDLE: begin
                if (bus.i_sop) begin
                    w_state_nxt = S_LOAD;
                    w_wptr_nxt  = '0;
                end
            end
            S_LOAD: begin
                w_wr_en = bus.i_valid;
                if (bus.i_eop) begin
                    w_state_nxt = S_RUN;
                    w_base_nxt  = '0;
                    w_rsel_nxt  = '0;
                end else if (bus.i_chblk) begin
                    w_wptr_nxt  = w_wptr_inc;
                end
            end
            S_RUN: begin
                if (bus.i_eop) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.i_chblk) begin
                    // The N oldest rows are overwritten in place, starting at the old base
                    w_state_nxt = S_REFILL;
                    w_wptr_nxt  = r_base;
                    w_fill_nxt  = '0;
                    w_base_nxt  = (w_base_sum >= c_M) ? BASE_W'(w_base_sum - c_M)
                                                      : w_base_sum[BASE_W-1:0];
                end
            end
            S_REFILL: begin
                w_wr_en = bus.i_valid;
                if (bus.i_eop) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.i_chblk) begin
                    w_wptr_nxt = w_wptr_inc;
                    w_fill_nxt = r_fill + FILL_W'(1);
                    if (r_fill == c_LAST_FILL) begin
                        w_state_nxt = S_RUN;
                        w_rsel_nxt  = '0;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_we = '0;
        for (int b = 0; b < M; b++)
            w_we[b] = w_wr_en && !rst && (r_wptr == BASE_W'(b));
    end

    assign w_memdata = {M{bus.i_Data}};

    always_comb begin
        w_data = '0;
        for (int j = 0; j < N; j++)
            if (r_rsel == RSEL_W'(j))
                w_data = bus.i_DataConv[j*BITS_IMAGEN +: BITS_IMAGEN];
    end

    generate
        for (genvar j = 0; j < N; j++) begin : g_lane
            for (genvar t = 0; t < K; t++) begin : g_tap
                localparam logic [BASE_W:0] c_OFF = (BASE_W + 1)'(j + t);
                logic [BASE_W:0]        w_sum;
                logic [BASE_W:0]        w_bank;
                logic [BITS_IMAGEN-1:0] w_pix;

                // j+t never exceeds M-1, so one conditional subtract suffices
                always_comb begin
                    w_sum  = {1'b0, r_base} + c_OFF;
                    w_bank = (w_sum >= c_M) ? (w_sum - c_M) : w_sum;
                    w_pix  = '0;
                    for (int b = 0; b < M; b++)
                        if (w_bank == (BASE_W + 1)'(b))
                            w_pix = bus.i_MemData[b*BITS_IMAGEN +: BITS_IMAGEN];
                end

                assign w_taps[(j*K + t)*BITS_IMAGEN +: BITS_IMAGEN] = w_pix;
            end
        end
    endgenerate

`ifdef MCU_OREG_EN
    logic [K*N*BITS_IMAGEN-1:0] r_taps;
    logic [M*BITS_IMAGEN-1:0]   r_memdata;
    logic [M-1:0]               r_we;
    logic [BITS_DATA-1:0]       r_data;
    logic [BITS_ADDR-1:0]       r_waddr;
    logic [BITS_ADDR-1:0]       r_raddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_taps    <= '0;
            r_memdata <= '0;
            r_we      <= '0;
            r_data    <= '0;
            r_waddr   <= '0;
            r_raddr   <= '0;
        end else begin
            r_taps    <= w_taps;
            r_memdata <= w_memdata;
            r_we      <= w_we;
            r_data    <= w_data;
            r_waddr   <= bus.i_WAddr;
            r_raddr   <= bus.i_RAddr;
        end
    end

    assign bus.o_DataConv = r_taps;
    assign bus.o_MemData  = r_memdata;
    assign bus.o_we       = r_we;
    assign bus.o_Data     = r_data;
    assign bus.o_WAddr    = r_waddr;
    assign bus.o_RAddr    = r_raddr;
`else
    assign bus.o_DataConv = w_taps;
    assign bus.o_MemData  = w_memdata;
    assign bus.o_we       = w_we;
    assign bus.o_Data     = w_data;
    assign bus.o_WAddr    = bus.i_WAddr;
    assign bus.o_RAddr    = bus.i_RAddr;
`endif

    assign bus.o_state = r_state;
    assign bus.o_base  = r_base;

endmodule
`default_nettype wire
